// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the BCD-to-binary and binary-to-BCD converters.
package bcd_pkg;

    localparam int NUM_DIGITS = 5;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [NUM_DIGITS-1:0][3:0] bcd_word_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WORK = 1'b1;

    function automatic logic has_bad_digit(input bcd_word_t word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word[i] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bin_mul10_add.sv
// One fold step of the conversion: sum = acc*10 + digit, with carry_out
// flagging any bits lost above the accumulator width.
module mul10_add
    import bcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] acc,
    input  bcd_digit_t     digit,
    output logic [WIDTH:0] sum,
    output logic           carry_out
);

    logic [WIDTH+4:0] wide;

    // Four guard bits hold the largest possible x10 + 15 result without loss.
    assign wide      = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                     + {{(WIDTH+1){1'b0}}, digit};
    assign sum       = wide[WIDTH:0];
    assign carry_out = |wide[WIDTH+4:WIDTH+1];

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative five-digit BCD to binary converter, one digit per clock, MSD first,
// with ready/load/done handshake, digit-range check and saturating overflow.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [3:0]       dig_5,
    input  logic [3:0]       dig_4,
    input  logic [3:0]       dig_3,
    input  logic [3:0]       dig_2,
    input  logic [3:0]       dig_1,
    output logic [WIDTH-1:0] number,
    output logic             ready,
    output logic             done,
    output logic             err_digit,
    output logic             overflow
);

    logic [0:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    bcd_word_t        digits_q, digits_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] number_q, number_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             overflow_q, overflow_d;

    bcd_word_t        in_word;
    logic [WIDTH:0]   step_sum;
    logic             step_carry;

    assign in_word = {dig_5, dig_4, dig_3, dig_2, dig_1};

    mul10_add #(
        .WIDTH(WIDTH)
    ) u_mul10_add (
        .acc      (acc_q),
        .digit    (digits_q[idx_q]),
        .sum      (step_sum),
        .carry_out(step_carry)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        digits_d   = digits_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        number_d   = number_q;
        done_d     = 1'b0;
        err_d      = err_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    digits_d   = in_word;
                    err_d      = 1'b0;
                    overflow_d = 1'b0;
                    // A bad digit is reported immediately without entering WORK.
                    if (has_bad_digit(in_word)) begin
                        err_d    = 1'b1;
                        number_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        idx_d   = 3'd4;
                        state_d = ST_WORK;
                    end
                end
            end
            default: begin
                acc_d = step_sum;
                ovf_d = ovf_q | step_carry;
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    if (step_sum[WIDTH] || ovf_d) begin
                        number_d   = '1;
                        overflow_d = 1'b1;
                    end else begin
                        number_d = step_sum[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            digits_q   <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            number_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            digits_q   <= digits_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            number_q   <= number_d;
            done_q     <= done_d;
            err_q      <= err_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign number    = number_q;
    assign done      = done_q;
    assign err_digit = err_q;
    assign overflow  = overflow_q;

endmodule
